assertions: RTL and testbench



---
 rtl/assertions_pkg.sv | 9 +
 rtl/assertions_pipe_reg.sv | 19 +
 rtl/assertions.sv | 49 ++++
 tb/tb_assertions.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/assertions_pkg.sv
// Shared constants for the assertions pipeline: per-output latencies and flop reset value.
package assertions_pkg;

    localparam int   C_LATENCY = 1;
    localparam int   D_LATENCY = 2;
    localparam int   E_LATENCY = 2;
    localparam logic RST_VAL   = 1'b0;

endpackage : assertions_pkg

// File: rtl/assertions_pipe_reg.sv
// Single-bit pipeline flop with asynchronous active-low reset to RST_VAL.
module pipe_reg
    import assertions_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : pipe_reg

// File: rtl/assertions.sv
// Two-stage registered AND/XOR pipeline used as a known-timing target for property checks.
// Optional macro ASSERTIONS_SVA_EN compiles in concurrent assertions on the output timing.
module assertions
    import assertions_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    output logic c_ou,
    output logic d_ou,
    output logic e_ou
);

    logic a_q;
    logic b_q;
    logic and_term;
    logic xor_term;

    // AND is formed from live inputs; XOR from the stage-1 copies so e_ou lines up with d_ou.
    assign and_term = a_in & b_in;
    assign xor_term = a_q ^ b_q;

    pipe_reg u_a_q (.clk(clk), .rst_n(rst_n), .d(a_in),     .q(a_q));
    pipe_reg u_b_q (.clk(clk), .rst_n(rst_n), .d(b_in),     .q(b_q));
    pipe_reg u_c   (.clk(clk), .rst_n(rst_n), .d(and_term), .q(c_ou));
    pipe_reg u_d   (.clk(clk), .rst_n(rst_n), .d(c_ou),     .q(d_ou));
    pipe_reg u_e   (.clk(clk), .rst_n(rst_n), .d(xor_term), .q(e_ou));

`ifdef ASSERTIONS_SVA_EN
    a_c_implies_d: assert property (@(posedge clk) disable iff (!rst_n)
        c_ou |=> d_ou)
        else $error("a_c_implies_d");

    a_c_from_and: assert property (@(posedge clk) disable iff (!rst_n)
        c_ou |-> $past(a_in & b_in))
        else $error("a_c_from_and");

    a_d_past_c: assert property (@(posedge clk) disable iff (!rst_n)
        d_ou == $past(c_ou))
        else $error("a_d_past_c");

    a_e_past_xor: assert property (@(posedge clk) disable iff (!rst_n)
        e_ou == $past(a_in ^ b_in, E_LATENCY))
        else $error("a_e_past_xor");
`else
`endif

endmodule : assertions

// File: tb/tb_assertions.sv
// Scoreboard bench for the assertions pipeline: expected outputs queued at drive time, popped after each edge.
module tb_assertions;

    logic clk;
    logic rst_n;
    logic a_in;
    logic b_in;
    logic c_ou;
    logic d_ou;
    logic e_ou;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic c;
        logic d;
        logic e;
    } exp_t;

    exp_t exp_q[$];

    // input history: index 0 = most recently sampled edge, index 1 = the edge before
    logic [1:0] a_hist;
    logic [1:0] b_hist;

    assertions dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a_in (a_in),
        .b_in (b_in),
        .c_ou (c_ou),
        .d_ou (d_ou),
        .e_ou (e_ou)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // called after a negedge with rst_n high; drives inputs, queues expectation, checks after posedge
    task automatic step(input logic a, input logic b);
        exp_t e;
        exp_t got;
        a_in = a;
        b_in = b;
        a_hist = {a_hist[0], a};
        b_hist = {b_hist[0], b};
        e.c = a_hist[0] & b_hist[0];
        e.d = a_hist[1] & b_hist[1];
        e.e = a_hist[1] ^ b_hist[1];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1'b1, 1'b0);
        end else begin
            got = exp_q.pop_front();
            chk("c_ou", c_ou, got.c);
            chk("d_ou", d_ou, got.d);
            chk("e_ou", e_ou, got.e);
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c"}, c_ou, 1'b0);
        chk({tag, "_d"}, d_ou, 1'b0);
        chk({tag, "_e"}, e_ou, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        a_in   = 1'b1;
        b_in   = 1'b1;
        a_hist = 2'b00;
        b_hist = 2'b00;

        // reset held across a posedge (t=5) with inputs high
        #3;
        chk_all_zero("rst_early");
        #6;
        chk_all_zero("rst_late");
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after release: c=1, d=0, e=0
        step(1'b1, 1'b1);

        // AND path
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // XOR path
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // random
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // async reset mid-stream with pipeline full of ones
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        a_hist = 2'b00;
        b_hist = 2'b00;
        rst_n  = 1'b1;

        // stage 1 restarts from reset values; old contents must not reappear
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_assertions
